fir_serial_mac: RTL and testbench

// - Multi-filter FIR wavelet engine; successor to the fixed single-filter parallel FIR.
// - Holds NUM_FILTERS runtime-programmable coefficient sets and one shared signed multiplier.
// - Computes one MAC per cycle, then rounds and saturates each result.
// - Sits between the input sample shift register and the wavelet output mux.

---
 rtl/fir_serial_mac_pkg.sv | 14 +
 rtl/fir_serial_mac_if.sv | 32 +++
 rtl/fir_round_sat.sv | 41 ++++
 rtl/fir_serial_mac.sv | 138 +++++++++++++
 tb/tb_fir_serial_mac.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fir_serial_mac_pkg.sv
// rtl/fir_serial_mac_pkg.sv - shared FSM encodings and accumulator sizing for the serial FIR MAC
package fir_serial_mac_pkg;

  // FSM state encodings kept as plain vectors for legacy tooling compatibility
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Signed accumulator width: full product plus growth for NUM_ELEM terms plus a sign guard
  function automatic int acc_bits(input int bits_per_elem, input int num_elem);
    return 2 * bits_per_elem + $clog2(num_elem) + 1;
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// rtl/fir_serial_mac_if.sv - request, coefficient-write and result bundle of the serial FIR MAC
interface fir_serial_mac_if #(
  parameter int BITS_PER_ELEM  = 8,
  parameter int NUM_ELEM       = 7,
  parameter int NUM_FILTERS    = 4,
  parameter int SUM_TRUNCATION = 8
);

  logic                                    i_start_calc;
  logic [NUM_ELEM*BITS_PER_ELEM-1:0]       i_taps;
  logic                                    o_busy;
  logic                                    i_coef_we;
  logic [$clog2(NUM_FILTERS)-1:0]          i_coef_filt;
  logic [$clog2(NUM_ELEM)-1:0]             i_coef_idx;
  logic [BITS_PER_ELEM-1:0]                i_coef_data;
  logic [NUM_FILTERS*SUM_TRUNCATION-1:0]   o_wavelet;
  logic [NUM_FILTERS-1:0]                  o_sat;
  logic                                    o_valid;

  // Requester side: issues runs and programs coefficients
  modport master (
    output i_start_calc, i_taps, i_coef_we, i_coef_filt, i_coef_idx, i_coef_data,
    input  o_busy, o_wavelet, o_sat, o_valid
  );

  // Engine side
  modport slave (
    input  i_start_calc, i_taps, i_coef_we, i_coef_filt, i_coef_idx, i_coef_data,
    output o_busy, o_wavelet, o_sat, o_valid
  );

endinterface

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - combinational round, arithmetic shift and saturate of one accumulator
module fir_round_sat #(
  parameter int ACC_BITS       = 20,
  parameter int SHIFT          = 11,
  parameter int ROUND          = 1,
  parameter int SUM_TRUNCATION = 8
) (
  input  logic signed [ACC_BITS-1:0]       acc,
  output logic signed [SUM_TRUNCATION-1:0] result,
  output logic                             sat
);

  // One extra bit so the rounding bias can never wrap the accumulator
  localparam int EW  = ACC_BITS + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EW-1:0] ONE = 1;
  localparam logic signed [EW-1:0] BIAS = (ROUND != 0 && SHIFT > 0) ? (ONE << RSH) : {EW{1'b0}};
  localparam logic signed [EW-1:0] MAXV =
    {{(EW + 1 - SUM_TRUNCATION){1'b0}}, {(SUM_TRUNCATION - 1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW + 1 - SUM_TRUNCATION){1'b1}}, {(SUM_TRUNCATION - 1){1'b0}}};

  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] shifted;

  // Bias, shift, then clamp to the signed output range and flag any clamp
  always_comb begin
    biased  = $signed({acc[ACC_BITS-1], acc}) + BIAS;
    shifted = biased >>> SHIFT;
    result  = shifted[SUM_TRUNCATION-1:0];
    sat     = 1'b0;
    if (shifted > MAXV) begin
      result = MAXV[SUM_TRUNCATION-1:0];
      sat    = 1'b1;
    end else if (shifted < MINV) begin
      result = MINV[SUM_TRUNCATION-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - multi-filter FIR engine sharing one signed multiplier, one MAC per cycle
module fir_serial_mac
  import fir_serial_mac_pkg::*;
#(
  parameter int BITS_PER_ELEM  = 8,
  parameter int NUM_ELEM       = 7,
  parameter int NUM_FILTERS    = 4,
  parameter int SUM_TRUNCATION = 8,
  parameter int SHIFT          = 11,
  parameter int ROUND          = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_serial_mac_if.slave bus
);

  localparam int B        = BITS_PER_ELEM;
  localparam int ST       = SUM_TRUNCATION;
  localparam int ACC_BITS = acc_bits(BITS_PER_ELEM, NUM_ELEM);
  localparam int FW       = $clog2(NUM_FILTERS);
  localparam int KW       = $clog2(NUM_ELEM);
  localparam int NCOEF    = NUM_FILTERS * NUM_ELEM;
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_ELEM - 1);

  logic [1:0]                 state;
  logic [FW-1:0]              f_cnt;
  logic [KW-1:0]              k_cnt;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [B-1:0]        coef [NUM_FILTERS][NUM_ELEM];
  logic signed [B-1:0]        snap [NUM_ELEM];
  logic [NCOEF-1:0]           coef_wr;
  logic signed [B-1:0]        coef_sel;
  logic signed [B-1:0]        tap_sel;
  logic signed [2*B-1:0]      prod;
  logic [NUM_FILTERS*ST-1:0]  wavelet_q;
  logic [NUM_FILTERS-1:0]     sat_q;
  logic                       valid_q;
  logic signed [ST-1:0]       rs_result;
  logic                       rs_sat;

  assign bus.o_busy    = (state != ST_IDLE);
  assign bus.o_wavelet = wavelet_q;
  assign bus.o_sat     = sat_q;
  assign bus.o_valid   = valid_q;

  // One-hot write decode; writes are only honoured while idle, out-of-range indices match nothing
  always_comb begin
    coef_wr = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        coef_wr[f*NUM_ELEM+k] = bus.i_coef_we && (state == ST_IDLE) &&
                                (bus.i_coef_filt == FW'(f)) && (bus.i_coef_idx == KW'(k));
      end
    end
  end

  // Coefficient store
  always_ff @(posedge clk) begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        if (!rst_n) begin
          coef[f][k] <= '0;
        end else if (coef_wr[f*NUM_ELEM+k]) begin
          coef[f][k] <= bus.i_coef_data;
        end
      end
    end
  end

  // Shared multiplier operands and product
  always_comb begin
    coef_sel = coef[f_cnt][k_cnt];
    tap_sel  = snap[k_cnt];
    prod     = coef_sel * tap_sel;
  end

  fir_round_sat #(
    .ACC_BITS      (ACC_BITS),
    .SHIFT         (SHIFT),
    .ROUND         (ROUND),
    .SUM_TRUNCATION(ST)
  ) u_round_sat (
    .acc   (acc),
    .result(rs_result),
    .sat   (rs_sat)
  );

  // Sequencer: snapshot taps, accumulate one filter, write its slot, repeat for every filter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      f_cnt     <= '0;
      k_cnt     <= '0;
      acc       <= '0;
      wavelet_q <= '0;
      sat_q     <= '0;
      valid_q   <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) snap[k] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_start_calc) begin
            for (int k = 0; k < NUM_ELEM; k++) snap[k] <= bus.i_taps[k*B +: B];
            f_cnt <= '0;
            k_cnt <= '0;
            acc   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc + {{(ACC_BITS - 2*B){prod[2*B-1]}}, prod};
          if (k_cnt == K_LAST) begin
            state <= ST_WRITE;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          wavelet_q[f_cnt*ST +: ST] <= rs_result;
          sat_q[f_cnt]              <= rs_sat;
          acc                       <= '0;
          k_cnt                     <= '0;
          if (f_cnt == F_LAST) begin
            valid_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            f_cnt <= f_cnt + 1'b1;
            state <= ST_CALC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb/tb_fir_serial_mac.sv - directed self-checking bench for fir_serial_mac
module tb_fir_serial_mac;

  localparam int B  = 8;
  localparam int NE = 7;
  localparam int NF = 2;
  localparam int ST = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   nvalid;

  always #5 clk = ~clk;

  fir_serial_mac_if #(
    .BITS_PER_ELEM(B), .NUM_ELEM(NE), .NUM_FILTERS(NF), .SUM_TRUNCATION(ST)
  ) bus ();

  fir_serial_mac #(
    .BITS_PER_ELEM(B), .NUM_ELEM(NE), .NUM_FILTERS(NF), .SUM_TRUNCATION(ST),
    .SHIFT(4), .ROUND(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_coef(input int f, input int k, input logic [7:0] v);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_filt = 1'(f);
    bus.i_coef_idx  = 3'(k);
    bus.i_coef_data = v;
    tick();
    bus.i_coef_we   = 1'b0;
  endtask

  task automatic fill(input int f, input logic [7:0] v);
    for (int k = 0; k < NE; k++) set_coef(f, k, v);
  endtask

  // Count o_valid pulses over a bounded window after an acceptance edge
  task automatic watch(input int start_cycle, output int first, output int count);
    first = 0;
    count = 0;
    for (int c = start_cycle; c <= 40; c++) begin
      tick();
      if (bus.o_valid) begin
        count++;
        if (first == 0) first = c;
      end
    end
  endtask

  task automatic run(input logic [7:0] tv, output int first, output int count);
    bus.i_taps       = {NE{tv}};
    bus.i_start_calc = 1'b1;
    tick();
    bus.i_start_calc = 1'b0;
    watch(1, first, count);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.i_start_calc = 1'b0;
    bus.i_taps       = '0;
    bus.i_coef_we    = 1'b0;
    bus.i_coef_filt  = '0;
    bus.i_coef_idx   = '0;
    bus.i_coef_data  = '0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_wavelet", 32'(bus.o_wavelet), 32'h0);
    chk("reset_sat", 32'(bus.o_sat), 32'h0);

    run(8'h5A, lat, nvalid);
    chk("zero_coef_latency", 32'(lat), 32'd16);
    chk("zero_coef_nvalid", 32'(nvalid), 32'd1);
    chk("zero_coef_wavelet", 32'(bus.o_wavelet), 32'h0000);
    chk("zero_coef_sat", 32'(bus.o_sat), 32'h0);

    fill(0, 8'd1);
    run(8'd17, lat, nvalid);
    chk("ones_wavelet", 32'(bus.o_wavelet), 32'h0007);
    chk("ones_sat", 32'(bus.o_sat), 32'h0);

    fill(0, 8'd0);
    set_coef(0, 0, 8'd8);
    run(8'd1, lat, nvalid);
    chk("half_up_pos", 32'(bus.o_wavelet), 32'h0001);
    set_coef(0, 0, 8'hF8);
    run(8'd1, lat, nvalid);
    chk("half_up_neg", 32'(bus.o_wavelet), 32'h0000);
    chk("half_up_sat", 32'(bus.o_sat), 32'h0);

    fill(0, 8'd127);
    fill(1, 8'h80);
    run(8'd127, lat, nvalid);
    chk("sat_wavelet", 32'(bus.o_wavelet), 32'h807F);
    chk("sat_flags", 32'(bus.o_sat), 32'h3);

    // Busy-window disturbances: extra start at 3, tap change at 5, coef write at 7
    fill(0, 8'd1);
    fill(1, 8'd2);
    bus.i_taps       = {NE{8'd17}};
    bus.i_start_calc = 1'b1;
    tick();
    bus.i_start_calc = 1'b0;
    tick(); tick();
    bus.i_start_calc = 1'b1;
    tick();
    bus.i_start_calc = 1'b0;
    chk("busy_mid_run", 32'(bus.o_busy), 32'd1);
    tick();
    bus.i_taps = {NE{8'd100}};
    tick(); tick();
    bus.i_coef_we   = 1'b1;
    bus.i_coef_filt = 1'b0;
    bus.i_coef_idx  = 3'd0;
    bus.i_coef_data = 8'd100;
    tick();
    bus.i_coef_we   = 1'b0;
    watch(8, lat, nvalid);
    chk("busy_latency", 32'(lat), 32'd16);
    chk("busy_nvalid", 32'(nvalid), 32'd1);
    chk("busy_wavelet", 32'(bus.o_wavelet), 32'h0F07);
    run(8'd17, lat, nvalid);
    chk("busy_write_ignored", 32'(bus.o_wavelet), 32'h0F07);

    // Coefficient write in the same cycle as the accepted start
    bus.i_taps       = {NE{8'd17}};
    bus.i_coef_we    = 1'b1;
    bus.i_coef_filt  = 1'b0;
    bus.i_coef_idx   = 3'd0;
    bus.i_coef_data  = 8'd9;
    bus.i_start_calc = 1'b1;
    tick();
    bus.i_coef_we    = 1'b0;
    bus.i_start_calc = 1'b0;
    watch(1, lat, nvalid);
    chk("same_cycle_wavelet", 32'(bus.o_wavelet), 32'h0F10);

    set_coef(0, 7, 8'd50);
    run(8'd17, lat, nvalid);
    chk("out_of_range_idx", 32'(bus.o_wavelet), 32'h0F10);

    // Reset asserted at cycle 9 of a run
    bus.i_taps       = {NE{8'd17}};
    bus.i_start_calc = 1'b1;
    tick();
    bus.i_start_calc = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    chk("pre_abort_wavelet", 32'(bus.o_wavelet), 32'h0F10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_wavelet", 32'(bus.o_wavelet), 32'h0);
    chk("abort_sat", 32'(bus.o_sat), 32'h0);
    watch(20, lat, nvalid);
    chk("abort_no_valid", 32'(nvalid), 32'd0);
    run(8'd17, lat, nvalid);
    chk("post_abort_latency", 32'(lat), 32'd16);
    chk("post_abort_wavelet", 32'(bus.o_wavelet), 32'h0000);
    chk("post_abort_sat", 32'(bus.o_sat), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
